lsu_req: RTL and testbench

Load/store unit placed directly upstream of the data memory. It accepts one memory operation at a time from the execute stage and drives a request/acknowledge memory port with an 8-byte-aligned address, a byte write mask and lane-shifted store data. On a load it extracts the addressed bytes from the returned doubleword and sign- or zero-extends them according to funct3. It also detects misaligned or illegal operations and memory timeouts, and returns one result per operation to writeback over a valid/ready handshake.

---
 rtl/lsu_req_if.sv | 36 +++
 rtl/lsu_req.sv | 148 ++++++++++++++
 tb/tb_lsu_req.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_req_if.sv
// Execute-side, memory-side and writeback-side signals of the load/store unit.
// The slave modport is the LSU's view; the master modport is the environment's view.
interface lsu_req_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic        in_ren;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_err;

  modport slave (
    input  in_valid, in_wen, in_ren, in_funct3, in_addr, in_wdata,
    input  mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_wen, in_ren, in_funct3, in_addr, in_wdata,
    output mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  out_valid, out_data, out_err
  );
endinterface

// File: rtl/lsu_req.sv
// Single-outstanding load/store unit: aligns stores into byte lanes, extends loads,
// flags illegal/misaligned operations and memory timeouts.
module lsu_req #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_req_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q;
  logic        in_ready_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  mem_wmask_q;
  logic        out_valid_q;
  logic        out_err_q;
  logic [63:0] out_data_q;
  logic [15:0] cnt_q;
  logic [2:0]  funct3_q;
  logic [2:0]  off_q;

  logic        bad_op;
  logic [2:0]  size_m;
  logic [7:0]  wmask_d;
  logic [63:0] wdata_d;
  logic [63:0] rshift;
  logic [63:0] load_d;

  // Decode of the offered operation, used only on the accepting cycle.
  always_comb begin
    size_m = 3'd0;
    wmask_d = 8'h00;
    unique case (bus.in_funct3[1:0])
      2'd0: begin size_m = 3'd0; wmask_d = 8'h01; end
      2'd1: begin size_m = 3'd1; wmask_d = 8'h03; end
      2'd2: begin size_m = 3'd3; wmask_d = 8'h0f; end
      default: begin size_m = 3'd7; wmask_d = 8'hff; end
    endcase
    wmask_d = bus.in_wen ? (wmask_d << bus.in_addr[2:0]) : 8'h00;
    wdata_d = bus.in_wdata << {bus.in_addr[2:0], 3'b000};
    bad_op  = (bus.in_wen == bus.in_ren) ||
              (bus.in_wen && bus.in_funct3[2]) ||
              (bus.in_ren && (bus.in_funct3 == 3'b111)) ||
              (|(bus.in_addr[2:0] & size_m));
  end

  always_comb begin
    rshift = bus.mem_rdata >> {off_q, 3'b000};
    load_d = '0;
    case (funct3_q)
      3'b000:  load_d = {{56{rshift[7]}}, rshift[7:0]};
      3'b001:  load_d = {{48{rshift[15]}}, rshift[15:0]};
      3'b010:  load_d = {{32{rshift[31]}}, rshift[31:0]};
      3'b011:  load_d = rshift;
      3'b100:  load_d = {56'd0, rshift[7:0]};
      3'b101:  load_d = {48'd0, rshift[15:0]};
      3'b110:  load_d = {32'd0, rshift[31:0]};
      default: load_d = '0;
    endcase
    if (mem_we_q) load_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          // in_ready_q gates acceptance so the cycle right after reset never accepts.
          if (bus.in_valid && in_ready_q) begin
            in_ready_q  <= 1'b0;
            funct3_q    <= bus.in_funct3;
            off_q       <= bus.in_addr[2:0];
            mem_we_q    <= bus.in_wen;
            mem_addr_q  <= {bus.in_addr[63:3], 3'b000};
            mem_wdata_q <= wdata_d;
            mem_wmask_q <= wmask_d;
            cnt_q       <= '0;
            if (bad_op) begin
              state_q     <= StResp;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_data_q  <= '0;
            end else begin
              state_q   <= StReq;
              mem_req_q <= 1'b1;
            end
          end
        end
        StReq: begin
          if (bus.mem_ack) begin
            state_q     <= StResp;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b0;
            out_data_q  <= load_d;
          end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= StResp;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            out_data_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StResp: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lsu_req.sv
// Directed bench for lsu_req: per-op reference model plus a per-cycle output monitor.
module tb_lsu_req;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if bus ();

  lsu_req #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  logic [63:0] exp_addr, exp_wdata, exp_data;
  logic [7:0]  exp_mask;
  logic        exp_we, exp_err, exp_noreq;
  logic [63:0] cap_addr, cap_wdata, cap_data;
  logic [7:0]  cap_mask;
  logic        cap_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit m_bad(input bit wen, input bit ren, input logic [2:0] f3,
                               input logic [63:0] a);
    int sz = 1 << f3[1:0];
    if (wen == ren) return 1'b1;
    if (wen && f3 >= 3'd4) return 1'b1;
    if (ren && f3 == 3'd7) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [7:0] m_mask(input logic [2:0] f3, input logic [63:0] a);
    int sz = 1 << f3[1:0];
    logic [15:0] m = ((16'd1 << sz) - 16'd1) << (a % 8);
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a,
                                         input logic [63:0] rd);
    int bits = 8 * (1 << f3[1:0]);
    logic [63:0] v = rd >> (8 * (a % 8));
    logic [63:0] m = (bits == 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
    v = v & m;
    if (f3 < 3'd4 && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  // Monitor: every cycle, whatever the DUT presents must match the current op's model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_excl", {63'd0, bus.in_ready && (bus.out_valid || bus.mem_req)}, 64'd0);
      if (bus.mem_req) begin
        chk("req_on_err", {63'd0, exp_noreq}, 64'd0);
        chk("mem_addr", bus.mem_addr, exp_addr);
        chk("mem_we", {63'd0, bus.mem_we}, {63'd0, exp_we});
        chk("mem_wmask", {56'd0, bus.mem_wmask}, {56'd0, exp_mask});
        if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      if (bus.out_valid) begin
        chk("out_data", bus.out_data, exp_data);
        chk("out_err", {63'd0, bus.out_err}, {63'd0, exp_err});
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !bus.in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
  endtask

  // ack_d: REQ cycle index (0 = first) in which mem_ack is given; negative = never.
  task automatic do_op(input bit wen, input bit ren, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input int ack_d,
                       input logic [63:0] rd, input int hold);
    bit b  = m_bad(wen, ren, f3, a);
    bit to = !b && (ack_d < 0 || ack_d >= int'(TO));
    int c;
    int reqc;
    int exp_n;
    exp_we    = wen;
    exp_addr  = a & ~64'h7;
    exp_mask  = wen ? m_mask(f3, a) : 8'h00;
    exp_wdata = wd << (8 * (a % 8));
    exp_noreq = b;
    exp_err   = b || to;
    exp_data  = (b || to || wen) ? 64'd0 : m_load(f3, a, rd);
    exp_n     = b ? 0 : (to ? int'(TO) : ack_d + 1);
    wait_ready();
    bus.in_wen = wen; bus.in_ren = ren; bus.in_funct3 = f3;
    bus.in_addr = a; bus.in_wdata = wd; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reqc = 0; cap_addr = '0; cap_mask = '0; cap_wdata = '0;
    c = 0;
    while (c < 40 && !bus.out_valid) begin
      if (bus.mem_req) begin
        if (reqc == 0) begin
          cap_addr = bus.mem_addr; cap_mask = bus.mem_wmask; cap_wdata = bus.mem_wdata;
        end
        reqc++;
        bus.mem_ack = (c == ack_d);
        bus.mem_rdata = rd;
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      c++;
    end
    chk("latency", 64'(c), 64'(exp_n));
    chk("req_cycles", 64'(reqc), 64'(exp_n));
    cap_data = bus.out_data;
    cap_err  = bus.out_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_data", bus.out_data, cap_data);
      chk("hold_err", {63'd0, bus.out_err}, {63'd0, cap_err});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("resp_done", {63'd0, bus.out_valid}, 64'd0);
    chk("in_ready_back", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_wen = 0; bus.in_ren = 0; bus.in_funct3 = 0;
    bus.in_addr = 0; bus.in_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    bus.out_ready = 0;
    exp_noreq = 1; exp_we = 0; exp_addr = 0; exp_mask = 0; exp_wdata = 0;
    exp_data = 0; exp_err = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_err", {63'd0, bus.out_err}, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wmask", {56'd0, bus.mem_wmask}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    mon_en = 1'b1;

    // sd, ack in first REQ cycle
    do_op(1, 0, 3'b011, 64'h80008ff0, 64'h1122334455667788, 0, 64'd0, 0);
    chk("sd_addr", cap_addr, 64'h80008ff0);
    chk("sd_mask", {56'd0, cap_mask}, 64'hff);
    chk("sd_wdata", cap_wdata, 64'h1122334455667788);
    chk("sd_data", cap_data, 64'd0);
    // sb into lane 5
    do_op(1, 0, 3'b000, 64'h80000005, 64'hab, 1, 64'd0, 0);
    chk("sb_addr", cap_addr, 64'h80000000);
    chk("sb_mask", {56'd0, cap_mask}, 64'h20);
    chk("sb_wdata", cap_wdata, 64'h0000ab0000000000);
    // loads
    do_op(0, 1, 3'b000, 64'h80000003, 64'd0, 2, 64'h00000000f0000000, 0);
    chk("lb_data", cap_data, 64'hfffffffffffffff0);
    do_op(0, 1, 3'b100, 64'h80000003, 64'd0, 0, 64'h00000000f0000000, 1);
    chk("lbu_data", cap_data, 64'h00000000000000f0);
    do_op(0, 1, 3'b010, 64'h80000004, 64'd0, 0, 64'h8000000100000000, 0);
    chk("lw_data", cap_data, 64'hffffffff80000001);
    do_op(0, 1, 3'b101, 64'h80000006, 64'd0, 1, 64'h8001000000000000, 0);
    chk("lhu_data", cap_data, 64'h0000000000008001);
    // ack in the final timeout cycle still wins
    do_op(0, 1, 3'b001, 64'h8000000a, 64'd0, int'(TO) - 1, 64'h0000000080010000, 0);
    chk("lh_last_ack", cap_data, 64'hffffffffffff8001);
    chk("lh_last_err", {63'd0, cap_err}, 64'd0);
    // misaligned / illegal
    do_op(0, 1, 3'b010, 64'h80000002, 64'd0, 0, 64'hffffffffffffffff, 0);
    chk("lw_mis_err", {63'd0, cap_err}, 64'd1);
    do_op(1, 0, 3'b100, 64'h80000000, 64'h55, 0, 64'd0, 0);
    chk("sd_ill_err", {63'd0, cap_err}, 64'd1);
    do_op(1, 1, 3'b011, 64'h80000008, 64'h55, 0, 64'd0, 0);
    do_op(0, 0, 3'b011, 64'h80000008, 64'h55, 0, 64'd0, 0);
    do_op(0, 1, 3'b111, 64'h80000008, 64'd0, 0, 64'd0, 0);
    // timeout with 5 cycles of back-pressure
    do_op(0, 1, 3'b011, 64'h80000010, 64'd0, -1, 64'h1234, 5);
    chk("to_err", {63'd0, cap_err}, 64'd1);
    chk("to_data", cap_data, 64'd0);

    // reset while mem_req is high, then a stray ack right after release
    exp_we = 0; exp_addr = 64'h80000040; exp_mask = 0; exp_noreq = 0;
    exp_err = 0; exp_data = 0;
    wait_ready();
    bus.in_wen = 0; bus.in_ren = 1; bus.in_funct3 = 3'b011;
    bus.in_addr = 64'h80000040; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr_req_on", {63'd0, bus.mem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rr_req_drop", {63'd0, bus.mem_req}, 64'd0);
    chk("rr_addr_clr", bus.mem_addr, 64'd0);
    @(posedge clk); #1;
    chk("rr_in_ready_rst", {63'd0, bus.in_ready}, 64'd0);
    #2 rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'hdead;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("rr_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rr_no_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("rr_no_valid2", {63'd0, bus.out_valid}, 64'd0);
    // recovery
    do_op(0, 1, 3'b011, 64'h80000048, 64'd0, 0, 64'h0123456789abcdef, 0);
    chk("ld_after_rst", cap_data, 64'h0123456789abcdef);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
